// File: rtl/stack_pointers_if.sv
// Stack-pointer strobe and bus bundle.
// Strobes come from stack_control; outputs feed the data and index-address buses.
interface stack_pointers_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d_in;
  logic             n_load_0;
  logic             n_load_1;
  logic             up_0;
  logic             up_1;
  logic             down_0;
  logic             down_1;
  logic             n_oe_d_0;
  logic             n_oe_d_1;
  logic             n_oe_ia_0;
  logic             n_oe_ia_1;
  logic [WIDTH-1:0] d_out;
  logic             d_oe;
  logic [WIDTH-1:0] ia_out;
  logic             ia_oe;
  logic [WIDTH-1:0] sp0;
  logic [WIDTH-1:0] sp1;
  logic [1:0]       carry;
  logic [1:0]       borrow;
  logic             conflict;

  modport master (
    output d_in, n_load_0, n_load_1,
    output up_0, up_1, down_0, down_1,
    output n_oe_d_0, n_oe_d_1,
    output n_oe_ia_0, n_oe_ia_1,
    input  d_out, d_oe, ia_out, ia_oe,
    input  sp0, sp1, carry, borrow, conflict
  );

  modport slave (
    input  d_in, n_load_0, n_load_1,
    input  up_0, up_1, down_0, down_1,
    input  n_oe_d_0, n_oe_d_1,
    input  n_oe_ia_0, n_oe_ia_1,
    output d_out, d_oe, ia_out, ia_oe,
    output sp0, sp1, carry, borrow, conflict
  );
endinterface

// File: rtl/stack_pointers.sv
// Dual up/down stack-pointer counters (74x193 emulation).
// Counts on the release edge of active-low up/down pulses.
module stack_pointers #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input logic            clk,
  input logic            n_rst,
  stack_pointers_if.slave bus
);

  logic [1:0]       n_load;
  logic [1:0]       up;
  logic [1:0]       down;
  logic [1:0]       prev_up;
  logic [1:0]       prev_down;
  logic [1:0]       up_ev;
  logic [1:0]       down_ev;
  logic [1:0]       carry_n;
  logic [1:0]       borrow_n;
  logic [1:0]       carry_q;
  logic [1:0]       borrow_q;
  logic [WIDTH-1:0] sp   [2];
  logic [WIDTH-1:0] sp_n [2];

  assign n_load  = {bus.n_load_1, bus.n_load_0};
  assign up      = {bus.up_1, bus.up_0};
  assign down    = {bus.down_1, bus.down_0};
  assign up_ev   = ~prev_up & up;
  assign down_ev = ~prev_down & down;

  always_comb begin
    carry_n  = '0;
    borrow_n = '0;
    for (int i = 0; i < 2; i++) begin
      sp_n[i] = sp[i];
      unique case (1'b1)
        !n_load[i]: sp_n[i] = bus.d_in;
        n_load[i] && up_ev[i] && down_ev[i]: ;
        n_load[i] && up_ev[i] && !down_ev[i]: begin
          sp_n[i]    = sp[i] + 1'b1;
          carry_n[i] = &sp[i];
        end
        n_load[i] && !up_ev[i] && down_ev[i]: begin
          sp_n[i]     = sp[i] - 1'b1;
          borrow_n[i] = ~|sp[i];
        end
        default: ;
      endcase
    end
  end

  // Edge regs sample every cycle, so a release during load is consumed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sp[0]     <= RESET_VALUE;
      sp[1]     <= RESET_VALUE;
      prev_up   <= '1;
      prev_down <= '1;
      carry_q   <= '0;
      borrow_q  <= '0;
    end else begin
      sp[0]     <= sp_n[0];
      sp[1]     <= sp_n[1];
      prev_up   <= up;
      prev_down <= down;
      carry_q   <= carry_n;
      borrow_q  <= borrow_n;
    end
  end

  assign bus.sp0    = sp[0];
  assign bus.sp1    = sp[1];
  assign bus.carry  = carry_q;
  assign bus.borrow = borrow_q;

  // Pointer 0 wins when both enables of a pair are low.
  assign bus.d_oe  = ~(bus.n_oe_d_0 & bus.n_oe_d_1);
  assign bus.d_out = !bus.n_oe_d_0 ? sp[0] :
                     !bus.n_oe_d_1 ? sp[1] : '0;

  assign bus.ia_oe  = ~(bus.n_oe_ia_0 & bus.n_oe_ia_1);
  assign bus.ia_out = !bus.n_oe_ia_0 ? sp[0] :
                      !bus.n_oe_ia_1 ? sp[1] : '0;

  assign bus.conflict =
    (!bus.n_oe_d_0 && !bus.n_oe_d_1) ||
    (!bus.n_oe_ia_0 && !bus.n_oe_ia_1);

endmodule

// File: tb/tb_stack_pointers.sv
// Self-checking bench for stack_pointers.
// Vector table feeds a scoreboard queue checked one cycle later.
module tb_stack_pointers;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  stack_pointers_if #(.WIDTH(8)) bus ();

  stack_pointers #(.WIDTH(8), .RESET_VALUE(8'hFF)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] ld;
    logic [1:0] up;
    logic [1:0] dn;
    logic [1:0] oed;
    logic [1:0] oia;
    logic [7:0] din;
    logic [7:0] sp0;
    logic [7:0] sp1;
    logic [1:0] cy;
    logic [1:0] bw;
  } row_t;

  typedef struct {
    int         idx;
    logic [7:0] sp0;
    logic [7:0] sp1;
    logic [1:0] cy;
    logic [1:0] bw;
    logic       d_oe;
    logic [7:0] d_out;
    logic       ia_oe;
    logic [7:0] ia_out;
    logic       conflict;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];

  function automatic row_t mk(
    logic [1:0] ld, logic [1:0] up, logic [1:0] dn,
    logic [1:0] oed, logic [1:0] oia, logic [7:0] din,
    logic [7:0] sp0, logic [7:0] sp1,
    logic [1:0] cy, logic [1:0] bw);
    row_t r;
    r.ld = ld; r.up = up; r.dn = dn;
    r.oed = oed; r.oia = oia; r.din = din;
    r.sp0 = sp0; r.sp1 = sp1; r.cy = cy; r.bw = bw;
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(row_t r);
    bus.n_load_0  = r.ld[0];  bus.n_load_1  = r.ld[1];
    bus.up_0      = r.up[0];  bus.up_1      = r.up[1];
    bus.down_0    = r.dn[0];  bus.down_1    = r.dn[1];
    bus.n_oe_d_0  = r.oed[0]; bus.n_oe_d_1  = r.oed[1];
    bus.n_oe_ia_0 = r.oia[0]; bus.n_oe_ia_1 = r.oia[1];
    bus.d_in      = r.din;
  endtask

  function automatic logic [7:0] mux(logic [1:0] oe, logic [7:0] a, logic [7:0] b);
    if (!oe[0]) return a;
    if (!oe[1]) return b;
    return 8'h00;
  endfunction

  task automatic pop_check();
    exp_t e;
    string t;
    e = sb.pop_front();
    t = $sformatf("row%0d", e.idx);
    chk({t, ".sp0"}, bus.sp0, e.sp0);
    chk({t, ".sp1"}, bus.sp1, e.sp1);
    chk({t, ".carry"}, {6'd0, bus.carry}, {6'd0, e.cy});
    chk({t, ".borrow"}, {6'd0, bus.borrow}, {6'd0, e.bw});
    chk({t, ".d_oe"}, {7'd0, bus.d_oe}, {7'd0, e.d_oe});
    chk({t, ".d_out"}, bus.d_out, e.d_out);
    chk({t, ".ia_oe"}, {7'd0, bus.ia_oe}, {7'd0, e.ia_oe});
    chk({t, ".ia_out"}, bus.ia_out, e.ia_out);
    chk({t, ".conflict"}, {7'd0, bus.conflict}, {7'd0, e.conflict});
  endtask

  row_t idle;

  initial begin
    idle = mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00,
              8'h00, 8'h00, 2'b00, 2'b00);
    drive(idle);

    //       ld     up     dn     oed    oia    din    sp0    sp1    cy     bw
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'hFF, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 8'h40, 8'h40, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 8'h00, 8'h40, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 8'h00, 8'h40, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h41, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h41, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h41, 8'h00, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 8'h00, 8'h41, 8'h00, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h41, 8'hFF, 2'b00, 2'b10));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h41, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 8'hFF, 8'hFF, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 8'h00, 8'hFF, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h00, 8'hFF, 2'b01, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h00, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 8'h00, 8'h00, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h00, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 8'h00, 8'h00, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 8'h10, 8'h10, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h10, 8'hFF, 2'b00, 2'b00));
    rows.push_back(mk(2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 8'h12, 8'h12, 8'h12, 2'b00, 2'b00));
    rows.push_back(mk(2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 8'h34, 8'h12, 8'h34, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 8'h00, 8'h12, 8'h34, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 8'h00, 8'h12, 8'h34, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 8'h00, 8'h12, 8'h34, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b00, 2'b01, 8'h00, 8'h12, 8'h34, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 8'h00, 8'h12, 8'h34, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h13, 8'h35, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 8'h00, 8'h13, 8'h35, 2'b00, 2'b00));
    rows.push_back(mk(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 8'h00, 8'h12, 8'h36, 2'b00, 2'b00));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.sp0", bus.sp0, 8'hFF);
    chk("rst.sp1", bus.sp1, 8'hFF);
    chk("rst.carry", {6'd0, bus.carry}, 8'h00);
    chk("rst.borrow", {6'd0, bus.borrow}, 8'h00);
    chk("rst.d_oe", {7'd0, bus.d_oe}, 8'h00);
    chk("rst.conflict", {7'd0, bus.conflict}, 8'h00);
    n_rst = 1'b1;

    for (int i = 0; i < rows.size(); i++) begin
      exp_t e;
      @(negedge clk);
      if (sb.size() != 0) pop_check();
      drive(rows[i]);
      e.idx      = i;
      e.sp0      = rows[i].sp0;
      e.sp1      = rows[i].sp1;
      e.cy       = rows[i].cy;
      e.bw       = rows[i].bw;
      e.d_oe     = ~&rows[i].oed;
      e.d_out    = mux(rows[i].oed, rows[i].sp0, rows[i].sp1);
      e.ia_oe    = ~&rows[i].oia;
      e.ia_out   = mux(rows[i].oia, rows[i].sp0, rows[i].sp1);
      e.conflict = (rows[i].oed == 2'b00) || (rows[i].oia == 2'b00);
      sb.push_back(e);
    end
    @(negedge clk);
    if (sb.size() != 0) pop_check();
    drive(idle);

    // Strobe held low across reset release counts once
    @(negedge clk);
    n_rst = 1'b0;
    bus.up_0 = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("hold.sp0_low", bus.sp0, 8'hFF);
    bus.up_0 = 1'b1;
    @(negedge clk);
    chk("hold.sp0", bus.sp0, 8'h00);
    chk("hold.carry", {6'd0, bus.carry}, 8'h01);
    @(negedge clk);
    chk("hold.sp0_after", bus.sp0, 8'h00);
    chk("hold.carry_after", {6'd0, bus.carry}, 8'h00);

    // Reset mid-pulse: immediate return, no count on release
    bus.n_load_0 = 1'b0;
    bus.d_in = 8'h05;
    @(negedge clk);
    bus.n_load_0 = 1'b1;
    bus.up_0 = 1'b0;
    @(negedge clk);
    chk("mid.sp0_loaded", bus.sp0, 8'h05);
    #2 n_rst = 1'b0;
    #1 chk("mid.sp0_async", bus.sp0, 8'hFF);
    bus.up_0 = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid.sp0_final", bus.sp0, 8'hFF);
    chk("mid.carry", {6'd0, bus.carry}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
